// File: rtl/counter_bank_pkg.sv
// Shared definitions for counter_bank: register offsets, mode encodings,
// CTRL bit positions and the per-channel write request struct.
package counter_bank_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic [1:0] {
    MODE_ONESHOT  = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_SQUARE   = 2'b10,
    MODE_FREEUP   = 2'b11
  } mode_e;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IE       = 3;
  localparam int CTRL_PRE_LSB  = 8;

  // Decoded one-cycle write strobes for a single channel.
  typedef struct packed {
    logic ctrl_we;
    logic load_we;
    logic stat_we;
  } chan_wr_t;

endpackage

// File: rtl/counter_chan.sv
// One timer channel: prescaler, counter, sticky EXP flag and OUT level.
// Ports:
//   clk, rst_n  - clock / async active-low reset
//   wr, wdata   - decoded register write strobes and write data
//   ctrl_rd     - CTRL register readback (reserved bits 0)
//   load_rd     - LOAD register
//   count       - current counter value
//   exp, ie     - sticky expiry flag and interrupt enable
//   out         - channel output level
module counter_chan
  import counter_bank_pkg::*;
#(
  parameter int W  = 32,
  parameter int PW = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  chan_wr_t     wr,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] ctrl_rd,
  output logic [W-1:0] load_rd,
  output logic [W-1:0] count,
  output logic         exp,
  output logic         ie,
  output logic         out
);

  // Wide view of wdata so the PRE field can be sliced even when W < PW+8;
  // missing upper bits read as zero.
  localparam int XW = (PW + 8 > W) ? PW + 8 : W;

  logic [XW-1:0] wd_x;
  logic [XW-1:0] ctrl_x;
  logic          en;
  mode_e         mode;
  logic [PW-1:0] pre, pcnt;
  logic          wr_en, run, tick, evt, en_nx, out_nx;
  mode_e         wr_mode, mode_nx;
  logic          unused_wd;

  assign wd_x      = XW'(wdata);
  assign unused_wd = ^wd_x;
  assign wr_en     = wd_x[CTRL_EN];
  assign wr_mode   = mode_e'(wd_x[CTRL_MODE_LSB +: 2]);

  always_comb begin
    ctrl_x                       = '0;
    ctrl_x[CTRL_EN]              = en;
    ctrl_x[CTRL_MODE_LSB +: 2]   = mode;
    ctrl_x[CTRL_IE]              = ie;
    ctrl_x[CTRL_PRE_LSB +: PW]   = pre;
  end
  assign ctrl_rd = ctrl_x[W-1:0];

  // A CTRL write clearing EN freezes the channel in that same cycle.
  assign run  = en & ~(wr.ctrl_we & ~wr_en);
  assign tick = run & (pcnt == pre);

  always_comb begin
    evt = 1'b0;
    if (tick) evt = (mode == MODE_FREEUP) ? (&count) : (count == '0);
  end

  always_comb begin
    en_nx   = wr.ctrl_we ? wr_en : en;
    mode_nx = wr.ctrl_we ? wr_mode : mode;
    if (evt && mode == MODE_ONESHOT) en_nx = 1'b0;
    if (!en_nx) begin
      out_nx = (mode_nx == MODE_SQUARE) ? out : 1'b0;
    end else begin
      case (mode_nx)
        MODE_ONESHOT: out_nx = 1'b1;
        MODE_SQUARE:  out_nx = out ^ evt;
        default:      out_nx = evt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en      <= 1'b0;
      mode    <= MODE_ONESHOT;
      ie      <= 1'b0;
      pre     <= '0;
      pcnt    <= '0;
      load_rd <= '0;
      count   <= '0;
      exp     <= 1'b0;
      out     <= 1'b0;
    end else begin
      if (wr.load_we) load_rd <= wdata;

      if (wr.ctrl_we && !en && wr_en) begin
        count <= (wr_mode == MODE_FREEUP) ? '0 : load_rd;
        pcnt  <= '0;
      end else if (run) begin
        pcnt <= tick ? '0 : pcnt + PW'(1);
        if (tick) begin
          case (mode)
            MODE_ONESHOT: count <= evt ? count : count - W'(1);
            MODE_FREEUP:  count <= count + W'(1);
            default:      count <= evt ? load_rd : count - W'(1);
          endcase
        end
      end

      if (wr.ctrl_we) begin
        mode <= wr_mode;
        ie   <= wd_x[CTRL_IE];
        pre  <= wd_x[CTRL_PRE_LSB +: PW];
      end
      en  <= en_nx;
      // Expiry set takes priority over a same-cycle clear.
      exp <= evt | (exp & ~(wr.stat_we & wd_x[0]));
      out <= out_nx;
    end
  end

endmodule

// File: rtl/counter_bank.sv
// Multi-channel timer/counter bank on a simple register bus.
// Ports:
//   clk, RSTN      - clock / async active-low reset
//   we, re         - one-cycle write / read strobes
//   addr           - {channel, reg[1:0]}
//   wdata, rdata   - write data / registered read data (1-cycle latency)
//   irq            - registered OR of (EXP & IE) over channels
//   ch_out         - per-channel output levels
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 32,
  parameter int PW  = 8,
  localparam int AW = $clog2(NCH) + 2
) (
  input  logic           clk,
  input  logic           RSTN,
  input  logic           we,
  input  logic           re,
  input  logic [AW-1:0]  addr,
  input  logic [W-1:0]   wdata,
  output logic [W-1:0]   rdata,
  output logic           irq,
  output logic [NCH-1:0] ch_out
);

  logic [1:0]                reg_sel;
  logic [AW-1:0]             ch_field;
  logic [NCH-1:0][W-1:0]     ctrl_rd, load_rd, cnt_rd;
  logic [NCH-1:0]            exp, ie;
  logic [W-1:0]              rd_val;

  assign reg_sel  = addr[1:0];
  assign ch_field = addr >> 2;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    chan_wr_t wr;
    logic     sel;
    assign sel        = we && (ch_field == AW'(i));
    assign wr.ctrl_we = sel && (reg_sel == REG_CTRL);
    assign wr.load_we = sel && (reg_sel == REG_LOAD);
    assign wr.stat_we = sel && (reg_sel == REG_STATUS);

    counter_chan #(.W(W), .PW(PW)) u_chan (
      .clk     (clk),
      .rst_n   (RSTN),
      .wr      (wr),
      .wdata   (wdata),
      .ctrl_rd (ctrl_rd[i]),
      .load_rd (load_rd[i]),
      .count   (cnt_rd[i]),
      .exp     (exp[i]),
      .ie      (ie[i]),
      .out     (ch_out[i])
    );
  end

  // Channels >= NCH match no index and read 0.
  always_comb begin
    rd_val = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_field == AW'(c)) begin
        case (reg_sel)
          REG_CTRL:  rd_val = ctrl_rd[c];
          REG_LOAD:  rd_val = load_rd[c];
          REG_COUNT: rd_val = cnt_rd[c];
          default:   rd_val = W'({ch_out[c], exp[c]});
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      rdata <= '0;
      irq   <= 1'b0;
    end else begin
      if (re) rdata <= rd_val;
      irq <= |(exp & ie);
    end
  end

endmodule

// File: tb/tb_counter_bank.sv
module tb_counter_bank;

  logic        clk = 1'b0;
  logic        RSTN = 1'b0;
  logic        we = 0, re = 0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;
  logic [3:0]  ch_out;

  logic        we8 = 0, re8 = 0;
  logic [3:0]  addr8 = '0;
  logic [7:0]  wdata8 = '0;
  logic [7:0]  rdata8;
  logic        irq8;
  logic [3:0]  ch_out8;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rv;
  logic [7:0]  rv8;

  always #5 clk = ~clk;

  counter_bank #(.NCH(4), .W(32), .PW(8)) dut (
    .clk(clk), .RSTN(RSTN), .we(we), .re(re), .addr(addr), .wdata(wdata),
    .rdata(rdata), .irq(irq), .ch_out(ch_out));

  counter_bank #(.NCH(4), .W(8), .PW(8)) dut8 (
    .clk(clk), .RSTN(RSTN), .we(we8), .re(re8), .addr(addr8), .wdata(wdata8),
    .rdata(rdata8), .irq(irq8), .ch_out(ch_out8));

  // All tasks start and return just after a falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    we = 1; addr = a; wdata = d;
    @(negedge clk);
    we = 0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    re = 1; addr = a;
    @(negedge clk);
    re = 0;
    d = rdata;
  endtask

  task automatic wr8(input logic [3:0] a, input logic [7:0] d);
    we8 = 1; addr8 = a; wdata8 = d;
    @(negedge clk);
    we8 = 0;
  endtask

  task automatic rd8(input logic [3:0] a, output logic [7:0] d);
    re8 = 1; addr8 = a;
    @(negedge clk);
    re8 = 0;
    d = rdata8;
  endtask

  task automatic test_reset;
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    n_checks++; if ({irq, irq8} !== 2'b00) begin n_fail++; $display("FAIL reset_irq got %b exp 00", {irq, irq8}); end
    n_checks++; if ({ch_out, ch_out8} !== 8'h00) begin n_fail++; $display("FAIL reset_ch_out got %h exp 00", {ch_out, ch_out8}); end
    // ch0 periodic, LOAD=3, IE=1; events at cycles 4 and 8
    wr(4'd1, 32'd3);
    wr(4'd0, 32'h0000_000B);
    cyc(10);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq got %b exp 1", irq); end
    rd(4'd0, rv);
    n_checks++; if (rv !== 32'h0000_000B) begin n_fail++; $display("FAIL pre_reset_ctrl got %h exp 0000000b", rv); end
    #2 RSTN = 0;
    #1;
    n_checks++; if ({irq, ch_out, rdata} !== 37'h0) begin n_fail++; $display("FAIL async_reset irq=%b ch_out=%h rdata=%h exp all 0", irq, ch_out, rdata); end
    @(negedge clk);
    RSTN = 1;
    rd(4'd2, rv);
    n_checks++; if (rv !== 32'h0) begin n_fail++; $display("FAIL post_reset_count got %h exp 0", rv); end
    rd(4'd3, rv);
    n_checks++; if (rv !== 32'h0) begin n_fail++; $display("FAIL post_reset_status got %h exp 0", rv); end
    rd(4'd0, rv);
    n_checks++; if (rv !== 32'h0) begin n_fail++; $display("FAIL post_reset_ctrl got %h exp 0", rv); end
    n_checks++; if ({irq, ch_out} !== 5'h0) begin n_fail++; $display("FAIL post_reset_out irq=%b ch_out=%h exp 0", irq, ch_out); end
  endtask

  task automatic test_oneshot;
    wr(4'd1, 32'd5);
    wr(4'd0, 32'h0000_0009);
    n_checks++; if (ch_out[0] !== 1'b1) begin n_fail++; $display("FAIL oneshot_out_on got %b exp 1", ch_out[0]); end
    cyc(6);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_early got %b exp 0", irq); end
    n_checks++; if (ch_out[0] !== 1'b0) begin n_fail++; $display("FAIL oneshot_out_off got %b exp 0", ch_out[0]); end
    cyc(1);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL oneshot_irq got %b exp 1", irq); end
    rd(4'd0, rv);
    n_checks++; if (rv !== 32'h0000_0008) begin n_fail++; $display("FAIL oneshot_ctrl got %h exp 00000008", rv); end
    rd(4'd2, rv);
    n_checks++; if (rv !== 32'h0) begin n_fail++; $display("FAIL oneshot_count got %h exp 0", rv); end
    rd(4'd3, rv);
    n_checks++; if (rv !== 32'h1) begin n_fail++; $display("FAIL oneshot_status got %h exp 1", rv); end
    wr(4'd3, 32'h1);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL clear_irq_lag got %b exp 1", irq); end
    cyc(1);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL clear_irq_drop got %b exp 0", irq); end
    wr(4'd0, 32'h0);
  endtask

  task automatic test_periodic;
    int t[3];
    int nh;
    nh = 0;
    t[0] = 0; t[1] = 0; t[2] = 0;
    wr(4'd5, 32'd2);
    wr(4'd4, 32'h0000_0303);
    for (int k = 1; k <= 37; k++) begin
      @(negedge clk);
      if (ch_out[1]) begin
        if (nh < 3) t[nh] = k;
        nh++;
      end
    end
    n_checks++; if (nh !== 3) begin n_fail++; $display("FAIL periodic_pulses got %0d exp 3", nh); end
    n_checks++; if (t[0] !== 12) begin n_fail++; $display("FAIL periodic_t1 got %0d exp 12", t[0]); end
    n_checks++; if (t[1] !== 24) begin n_fail++; $display("FAIL periodic_t2 got %0d exp 24", t[1]); end
    n_checks++; if (t[2] !== 36) begin n_fail++; $display("FAIL periodic_t3 got %0d exp 36", t[2]); end
    wr(4'd4, 32'h0);
  endtask

  task automatic test_square;
    int exp_t[5] = '{10, 20, 30, 35, 40};
    int t[5];
    int nt;
    logic prev;
    nt = 0;
    for (int i = 0; i < 5; i++) t[i] = 0;
    wr(4'd9, 32'd9);
    wr(4'd8, 32'h0000_0005);
    prev = ch_out[2];
    for (int k = 1; k <= 42; k++) begin
      if (k == 25) begin we = 1; addr = 4'd9; wdata = 32'd4; end
      else we = 0;
      @(negedge clk);
      if (ch_out[2] !== prev) begin
        if (nt < 5) t[nt] = k;
        nt++;
        prev = ch_out[2];
      end
    end
    we = 0;
    n_checks++; if (nt !== 5) begin n_fail++; $display("FAIL square_toggles got %0d exp 5", nt); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (t[i] !== exp_t[i]) begin n_fail++; $display("FAIL square_t%0d got %0d exp %0d", i, t[i], exp_t[i]); end
    end
    wr(4'd8, 32'h0000_0004);
    n_checks++; if (ch_out[2] !== 1'b1) begin n_fail++; $display("FAIL square_hold got %b exp 1", ch_out[2]); end
    wr(4'd8, 32'h0);
    n_checks++; if (ch_out[2] !== 1'b0) begin n_fail++; $display("FAIL square_off got %b exp 0", ch_out[2]); end
  endtask

  task automatic test_freeup;
    wr8(4'd12, 8'h0F);
    cyc(255);
    n_checks++; if (irq8 !== 1'b0) begin n_fail++; $display("FAIL freeup_irq_early got %b exp 0", irq8); end
    rd8(4'd14, rv8);
    n_checks++; if (rv8 !== 8'd255) begin n_fail++; $display("FAIL freeup_count_max got %0d exp 255", rv8); end
    n_checks++; if (irq8 !== 1'b0) begin n_fail++; $display("FAIL freeup_irq_wrap got %b exp 0", irq8); end
    rd8(4'd14, rv8);
    n_checks++; if (rv8 !== 8'd0) begin n_fail++; $display("FAIL freeup_count_wrap got %0d exp 0", rv8); end
    n_checks++; if (irq8 !== 1'b1) begin n_fail++; $display("FAIL freeup_irq got %b exp 1", irq8); end
    rd8(4'd15, rv8);
    n_checks++; if (rv8 !== 8'h01) begin n_fail++; $display("FAIL freeup_status got %h exp 01", rv8); end
  endtask

  task automatic test_back_to_back;
    wr(4'd7, 32'h1);
    wr(4'd5, 32'd2);
    wr(4'd4, 32'h0000_000B);
    cyc(2);
    // STATUS clear lands on the same edge as the first event
    wr(4'd7, 32'h1);
    cyc(1);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL race_set_wins got %b exp 1", irq); end
    wr(4'd4, 32'h0000_000A);
    wr(4'd7, 32'h1);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL race_irq_lag got %b exp 1", irq); end
    cyc(1);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL race_irq_drop got %b exp 0", irq); end
    rd(4'd7, rv);
    n_checks++; if (rv !== 32'h0) begin n_fail++; $display("FAIL race_status got %h exp 0", rv); end
  endtask

  initial begin
    cyc(3);
    RSTN = 1;
    cyc(1);
    test_reset;
    test_oneshot;
    test_periodic;
    test_square;
    test_freeup;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
